bcd_down_timer: RTL and testbench

- Cascaded BCD decade down-counter (timer) with preset load, start/hold control and a terminal-count pulse.
- Complements the team's decade up-counter.
- Used for countdown displays and interval timing in the lab designs; each 4-bit digit of Q drives one 7-segment decoder.

---
 rtl/bcd_timer_pkg.sv | 18 +
 rtl/decade_down_cell.sv | 37 +++
 rtl/bcd_down_timer.sv | 142 ++++++++++++++
 tb/tb_bcd_down_timer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the cascaded BCD down-timer.
// The optional BCD_TIMER_AUTO_RELOAD_EN build is handled in bcd_down_timer.sv.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } timer_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Any non-decimal nibble saturates to 9 so the count never holds a non-BCD digit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/decade_down_cell.sv
// One BCD decade of the down-counter: load, decrement with 0 -> 9 borrow wrap.
module decade_down_cell
    import bcd_timer_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       dec_en,
    output logic [3:0] q,
    output logic       is_zero
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = clamp_digit(d);
        end else if (dec_en) begin
            q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign is_zero = (q_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Cascaded BCD down-timer with preset load, start/hold and a terminal-count pulse.
// Define BCD_TIMER_AUTO_RELOAD_EN to restart from the last preset at terminal count.
module bcd_down_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 1
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   PRE,
    input  logic                  START,
    input  logic                  HOLD,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ZERO
);

    localparam int QW = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [QW-1:0] Q_ONE      = QW'(1);

    timer_state_e      state_q;
    logic [PW-1:0]     presc_q;
    logic              done_q;

    logic [QW-1:0]     pre_clamped;
    logic [QW-1:0]     cell_d;
    logic              cell_load;
    logic [DIGITS-1:0] digit_zero;
    logic [DIGITS:0]   lower_zero;
    logic [DIGITS-1:0] dec_en;

    logic              counting;
    logic              presc_wrap;
    logic              tick;
    logic              q_is_zero;
    logic              terminal;
    logic              reload;
    logic              stay_run;

    // RUN and PAUSED both count whenever HOLD is low, so the resume edge is not lost.
    assign counting   = (state_q != IDLE) && !HOLD;
    assign presc_wrap = (presc_q == PRESC_LAST);
    assign tick       = counting && presc_wrap && !LOAD;
    assign q_is_zero  = lower_zero[DIGITS];
    assign terminal   = tick && (Q == Q_ONE);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    logic [QW-1:0] shadow_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            shadow_q <= '0;
        end else if (LOAD) begin
            shadow_q <= pre_clamped;
        end
    end

    // Q only rests at zero while running when the previous tick was terminal.
    assign reload    = tick && q_is_zero;
    assign stay_run  = (shadow_q != '0);
    assign cell_load = LOAD || reload;
    assign cell_d    = LOAD ? pre_clamped : shadow_q;
`else
    assign reload    = 1'b0;
    assign stay_run  = 1'b0;
    assign cell_load = LOAD;
    assign cell_d    = pre_clamped;
`endif

    assign lower_zero[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign pre_clamped[4*gi +: 4] = clamp_digit(PRE[4*gi +: 4]);
            assign lower_zero[gi+1]       = lower_zero[gi] && digit_zero[gi];
            assign dec_en[gi]             = tick && !reload && lower_zero[gi];

            decade_down_cell u_cell (
                .CLK     (CLK),
                .CLR     (CLR),
                .load    (cell_load),
                .d       (cell_d[4*gi +: 4]),
                .dec_en  (dec_en[gi]),
                .q       (Q[4*gi +: 4]),
                .is_zero (digit_zero[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= IDLE;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else if (LOAD) begin
            state_q <= IDLE;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        if (q_is_zero) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            presc_q <= '0;
                        end
                    end
                end
                RUN, PAUSED: begin
                    if (HOLD) begin
                        state_q <= PAUSED;
                    end else begin
                        presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
                        if (terminal) begin
                            done_q  <= 1'b1;
                            state_q <= stay_run ? RUN : IDLE;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    presc_q <= '0;
                end
            endcase
        end
    end

    assign BUSY = (state_q != IDLE);
    assign DONE = done_q;
    assign ZERO = q_is_zero;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a monitor pops and compares.
module tb_bcd_down_timer;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] pre = 8'h00;

    logic [7:0] q1, q4;
    logic       busy1, done1, zero1;
    logic       busy4, done4, zero4;

    always #5 clk = ~clk;

    bcd_down_timer #(.DIGITS(2), .TICK_DIV(1)) dut1 (
        .CLK(clk), .CLR(clr), .LOAD(load), .PRE(pre), .START(start), .HOLD(hold),
        .Q(q1), .BUSY(busy1), .DONE(done1), .ZERO(zero1)
    );

    bcd_down_timer #(.DIGITS(2), .TICK_DIV(4)) dut4 (
        .CLK(clk), .CLR(clr), .LOAD(load), .PRE(pre), .START(start), .HOLD(hold),
        .Q(q4), .BUSY(busy4), .DONE(done4), .ZERO(zero4)
    );

    typedef struct {
        int         cyc;
        int         id;
        int         sel;
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   id_ctr = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Drive one cycle of inputs and record what the selected DUT must show after the edge.
    task automatic step(input logic l, input logic [7:0] p, input logic s, input logic h,
                        input logic c, input int sel, input logic [7:0] eq,
                        input logic eb, input logic ed);
        exp_t e;
        @(negedge clk);
        clr   = c;
        load  = l;
        pre   = p;
        start = s;
        hold  = h;
        e.cyc  = cyc + 1;
        e.id   = id_ctr;
        e.sel  = sel;
        e.q    = eq;
        e.busy = eb;
        e.done = ed;
        id_ctr++;
        sb.push_back(e);
    endtask

    task automatic idle(input int sel, input logic [7:0] eq, input logic eb, input logic ed);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, sel, eq, eb, ed);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] aq;
        logic       ab, ad, az;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e  = sb.pop_front();
                aq = (e.sel == 0) ? q1    : q4;
                ab = (e.sel == 0) ? busy1 : busy4;
                ad = (e.sel == 0) ? done1 : done4;
                az = (e.sel == 0) ? zero1 : zero4;
                n_checks++;
                if (aq === e.q && ab === e.busy && ad === e.done && az === (e.q == 8'h00)) begin
                    n_pass++;
                end else begin
                    $display("FAIL chk%0d dut%0d: got Q=%h BUSY=%b DONE=%b ZERO=%b, want Q=%h BUSY=%b DONE=%b ZERO=%b",
                             e.id, (e.sel == 0) ? 1 : 4, aq, ab, ad, az,
                             e.q, e.busy, e.done, (e.q == 8'h00));
                end
                $display("chk%0d dut%0d Q=%h BUSY=%b DONE=%b ZERO=%b", e.id,
                         (e.sel == 0) ? 1 : 4, aq, ab, ad, az);
            end
        end
    end

    initial begin : stimulus
        // Reset state
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 8'h00, 1'b0, 1'b0);

        // CLR mid-run from 45
        step(1'b1, 8'h45, 1'b0, 1'b0, 1'b0, 0, 8'h45, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h45, 1'b1, 1'b0);
        idle(0, 8'h44, 1'b1, 1'b0);
        idle(0, 8'h43, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0);
        idle(0, 8'h00, 1'b0, 1'b0);

        // Full countdown from 12 with borrow across the decade
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 0, 8'h12, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h12, 1'b1, 1'b0);
        for (int v = 11; v >= 1; v--) idle(0, bcd(v), 1'b1, 1'b0);
        idle(0, 8'h00, 1'b0, 1'b1);
        idle(0, 8'h00, 1'b0, 1'b0);

        // Preset clamping, LOAD beating START, START with zero count
        step(1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, 0, 8'h99, 1'b0, 1'b0);
        step(1'b1, 8'hA7, 1'b0, 1'b0, 1'b0, 0, 8'h97, 1'b0, 1'b0);
        step(1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 0, 8'h21, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1);
        idle(0, 8'h00, 1'b0, 1'b0);

        // HOLD with TICK_DIV = 1: held edges freeze, release edge counts
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 0, 8'h03, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h03, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h03, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h03, 1'b1, 1'b0);
        idle(0, 8'h02, 1'b1, 1'b0);
        idle(0, 8'h01, 1'b1, 1'b0);
        idle(0, 8'h00, 1'b0, 1'b1);

        // TICK_DIV = 4, PRE 02, HOLD for 3 cycles: zero 11 edges after RUN entry
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1, 8'h02, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 8'h02, 1'b1, 1'b0);
        idle(1, 8'h02, 1'b1, 1'b0);
        idle(1, 8'h02, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 8'h02, 1'b1, 1'b0);
        idle(1, 8'h02, 1'b1, 1'b0);
        idle(1, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1, 8'h01, 1'b1, 1'b0);
        idle(1, 8'h00, 1'b0, 1'b1);
        idle(1, 8'h00, 1'b0, 1'b0);

        // LOAD mid-run aborts without DONE
        step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 0, 8'h05, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h05, 1'b1, 1'b0);
        idle(0, 8'h04, 1'b1, 1'b0);
        idle(0, 8'h03, 1'b1, 1'b0);
        step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 0, 8'h30, 1'b0, 1'b0);
        idle(0, 8'h30, 1'b0, 1'b0);
        idle(0, 8'h30, 1'b0, 1'b0);

        // Terminal-count behaviour from 02
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 0, 8'h02, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h02, 1'b1, 1'b0);
        idle(0, 8'h01, 1'b1, 1'b0);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        idle(0, 8'h00, 1'b1, 1'b1);
        idle(0, 8'h02, 1'b1, 1'b0);
        idle(0, 8'h01, 1'b1, 1'b0);
        idle(0, 8'h00, 1'b1, 1'b1);
        idle(0, 8'h02, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
`else
        idle(0, 8'h00, 1'b0, 1'b1);
        idle(0, 8'h00, 1'b0, 1'b0);
        idle(0, 8'h00, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
